// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with optional single-level interrupt.
//
// Optional feature macro: PC_SEQ_IRQ_EN. When it is defined, the sequencer has
// RUN/WAIT/ISR states, wfi/rfi and a level-sensitive irq. When it is undefined,
// the sequencer is a plain next-PC register. wfi/rfi then behave as pc+1, and
// the interrupt outputs are tied off. The ports are the same in both builds.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous active-high reset
//   pc_mux[1:0]      next-PC select: 0=ADD, 1=WREG, 2=LIT, 3=SAVE
//   opcode[4:0]      current opcode; opcode[4:1]=E is wfi, F is rfi
//   lit, w_reg       branch targets
//   skip             ALU skip flag (adds one more in ADD)
//   irq              level-sensitive interrupt request
//   stall            holds all state when high
//   pc, saved_pc     registered fetch address / return address
//   interrupt_active high in ISR
//   waiting          high in WAIT
//   fetch_valid      high when pc addresses an instruction to execute
module pc_sequencer #(
    parameter int unsigned          PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0]  IRQ_VECTOR   = PC_WIDTH'(4)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          pc_mux,
    input  logic [4:0]          opcode,
    input  logic [PC_WIDTH-1:0] lit,
    input  logic [PC_WIDTH-1:0] w_reg,
    input  logic                skip,
    input  logic                irq,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] saved_pc,
    output logic                interrupt_active,
    output logic                waiting,
    output logic                fetch_valid
);

    localparam logic [1:0] MUX_ADD  = 2'd0;
    localparam logic [1:0] MUX_WREG = 2'd1;
    localparam logic [1:0] MUX_LIT  = 2'd2;
    localparam logic [1:0] MUX_SAVE = 2'd3;

    logic [PC_WIDTH-1:0] npc;
    logic                rfi_restore;   // rfi executed in ISR: return to saved_pc
    logic                unused_inputs;

    // Next-PC candidate; all arithmetic wraps at PC_WIDTH bits.
    always_comb begin
        npc = pc + PC_WIDTH'(1);
        case (pc_mux)
            MUX_ADD:  npc = pc + PC_WIDTH'(1) + PC_WIDTH'(skip);
            MUX_WREG: npc = w_reg;
            MUX_LIT:  npc = lit;
            MUX_SAVE: npc = rfi_restore ? saved_pc : pc + PC_WIDTH'(1);
            default:  npc = pc + PC_WIDTH'(1);
        endcase
    end

`ifdef PC_SEQ_IRQ_EN

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ISR  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] saved_next;
    logic                is_wfi;
    logic                is_rfi;

    assign is_wfi        = (pc_mux == MUX_SAVE) && (opcode[4:1] == 4'hE);
    assign is_rfi        = (pc_mux == MUX_SAVE) && (opcode[4:1] == 4'hF);
    assign rfi_restore   = is_rfi && (state == ST_ISR);
    assign unused_inputs = opcode[0];

    // State, pc and return address; stall freezes everything, reset wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_RUN;
            pc       <= RESET_VECTOR;
            saved_pc <= '0;
        end else if (!stall) begin
            state    <= state_next;
            pc       <= pc_next;
            saved_pc <= saved_next;
        end
    end

    // Next state; an irq in RUN takes priority over a simultaneous wfi.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        saved_next = saved_pc;
        case (state)
            ST_RUN: begin
                if (irq) begin
                    saved_next = npc;
                    pc_next    = IRQ_VECTOR;
                    state_next = ST_ISR;
                end else begin
                    pc_next = npc;
                    if (is_wfi) state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (irq) begin
                    saved_next = pc;
                    pc_next    = IRQ_VECTOR;
                    state_next = ST_ISR;
                end
            end
            ST_ISR: begin
                // No nesting: irq is ignored until rfi has returned to RUN.
                pc_next = npc;
                if (is_rfi) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign interrupt_active = (state == ST_ISR);
    assign waiting          = (state == ST_WAIT);
    assign fetch_valid      = (state != ST_WAIT);

`else

    assign rfi_restore      = 1'b0;
    assign unused_inputs    = ^{irq, opcode};
    assign saved_pc         = '0;
    assign interrupt_active = 1'b0;
    assign waiting          = 1'b0;
    assign fetch_valid      = 1'b1;

    // Plain PC register: every unstalled edge takes the next-PC candidate.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (!stall) begin
            pc <= npc;
        end
    end

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default parameters). The expected
// values cover both builds: irq-enabled values apply when PC_SEQ_IRQ_EN is
// defined, and plain-PC values apply otherwise.
module tb_pc_sequencer;

`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [1:0] ADD  = 2'd0;
    localparam logic [1:0] WREG = 2'd1;
    localparam logic [1:0] LIT  = 2'd2;
    localparam logic [1:0] SAVE = 2'd3;
    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_WFI = 5'h1C;
    localparam logic [4:0] OP_RFI = 5'h1E;

    typedef struct packed {
        logic        rst;
        logic [1:0]  mux;
        logic [4:0]  op;
        logic [11:0] lit;
        logic [11:0] w;
        logic        skip;
        logic        irq;
        logic        stall;
    } stim_t;

    typedef struct packed {
        logic [11:0] pc;
        logic [11:0] saved;
        logic        ia;
        logic        wt;
        logic        fv;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pc_mux = ADD;
    logic [4:0]  opcode = OP_NOP;
    logic [11:0] lit = '0;
    logic [11:0] w_reg = '0;
    logic        skip = 1'b0;
    logic        irq = 1'b0;
    logic        stall = 1'b0;
    logic [11:0] pc;
    logic [11:0] saved_pc;
    logic        interrupt_active;
    logic        waiting;
    logic        fetch_valid;

    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];

    pc_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .pc_mux           (pc_mux),
        .opcode           (opcode),
        .lit              (lit),
        .w_reg            (w_reg),
        .skip             (skip),
        .irq              (irq),
        .stall            (stall),
        .pc               (pc),
        .saved_pc         (saved_pc),
        .interrupt_active (interrupt_active),
        .waiting          (waiting),
        .fetch_valid      (fetch_valid)
    );

    always #5 clock = ~clock;

    function automatic stim_t st(logic r, logic [1:0] m, logic [4:0] o, logic [11:0] l,
                                 logic [11:0] w, logic s, logic i, logic sl);
        return '{rst: r, mux: m, op: o, lit: l, w: w, skip: s, irq: i, stall: sl};
    endfunction

    // Expected outputs: irq-build values, then the pc for the plain build.
    function automatic obs_t mk(logic [11:0] p_irq, logic [11:0] s_irq, logic ia, logic wt,
                                logic fv, logic [11:0] p_plain);
        if (IRQ_EN) return '{pc: p_irq, saved: s_irq, ia: ia, wt: wt, fv: fv};
        return '{pc: p_plain, saved: 12'h000, ia: 1'b0, wt: 1'b0, fv: 1'b1};
    endfunction

    function automatic obs_t cur();
        return '{pc: pc, saved: saved_pc, ia: interrupt_active, wt: waiting, fv: fetch_valid};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pc=%h saved=%h ia=%b wait=%b fv=%b", o.pc, o.saved, o.ia, o.wt, o.fv);
    endfunction

    // Drive inputs on the falling edge, then sample 1ns after the rising edge.
    task automatic step(input stim_t s);
        @(negedge clock);
        reset  = s.rst;
        pc_mux = s.mux;
        opcode = s.op;
        lit    = s.lit;
        w_reg  = s.w;
        skip   = s.skip;
        irq    = s.irq;
        stall  = s.stall;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        s.push_back(st(1, ADD, OP_NOP, 12'h000, 12'h000, 0, 1, 1)); e.push_back(mk(12'h000, 12'h000, 0, 0, 1, 12'h000));
        s.push_back(st(1, LIT, OP_WFI, 12'h555, 12'h000, 1, 1, 0)); e.push_back(mk(12'h000, 12'h000, 0, 0, 1, 12'h000));
        foreach (s[k]) begin
            exp_q.push_back(e[k]);
            step(s[k]);
            got  = cur();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_add();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        s.push_back(st(0, ADD, OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h001, 12'h000, 0, 0, 1, 12'h001));
        s.push_back(st(0, ADD, OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h002, 12'h000, 0, 0, 1, 12'h002));
        s.push_back(st(0, ADD, OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h003, 12'h000, 0, 0, 1, 12'h003));
        s.push_back(st(0, ADD, OP_NOP, 12'h000, 12'h000, 1, 0, 0)); e.push_back(mk(12'h005, 12'h000, 0, 0, 1, 12'h005));
        foreach (s[k]) begin
            exp_q.push_back(e[k]);
            step(s[k]);
            got  = cur();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL add[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_wrap_branch();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        s.push_back(st(0, LIT,  OP_NOP, 12'hFFE, 12'h000, 0, 0, 0)); e.push_back(mk(12'hFFE, 12'h000, 0, 0, 1, 12'hFFE));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 1, 0, 0)); e.push_back(mk(12'h000, 12'h000, 0, 0, 1, 12'h000));
        s.push_back(st(0, LIT,  OP_NOP, 12'hFFF, 12'h000, 0, 0, 0)); e.push_back(mk(12'hFFF, 12'h000, 0, 0, 1, 12'hFFF));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 1, 0, 0)); e.push_back(mk(12'h001, 12'h000, 0, 0, 1, 12'h001));
        s.push_back(st(0, LIT,  OP_NOP, 12'h123, 12'h000, 0, 0, 0)); e.push_back(mk(12'h123, 12'h000, 0, 0, 1, 12'h123));
        s.push_back(st(0, WREG, OP_NOP, 12'h000, 12'h0AA, 1, 0, 0)); e.push_back(mk(12'h0AA, 12'h000, 0, 0, 1, 12'h0AA));
        s.push_back(st(0, SAVE, OP_NOP, 12'h000, 12'h000, 1, 0, 0)); e.push_back(mk(12'h0AB, 12'h000, 0, 0, 1, 12'h0AB));
        foreach (s[k]) begin
            exp_q.push_back(e[k]);
            step(s[k]);
            got  = cur();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL wrap_branch[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_wfi();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        s.push_back(st(0, LIT,  OP_NOP, 12'h010, 12'h000, 0, 0, 0)); e.push_back(mk(12'h010, 12'h000, 0, 0, 1, 12'h010));
        s.push_back(st(0, SAVE, OP_WFI, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h011, 12'h000, 0, 1, 0, 12'h011));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h011, 12'h000, 0, 1, 0, 12'h012));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h011, 12'h000, 0, 1, 0, 12'h013));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h011, 12'h000, 0, 1, 0, 12'h014));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h004, 12'h011, 1, 0, 1, 12'h015));
        s.push_back(st(0, SAVE, OP_RFI, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h011, 12'h011, 0, 0, 1, 12'h016));
        foreach (s[k]) begin
            exp_q.push_back(e[k]);
            step(s[k]);
            got  = cur();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL wfi[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_irq_priority();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        s.push_back(st(0, LIT,  OP_NOP, 12'h020, 12'h000, 0, 0, 0)); e.push_back(mk(12'h020, 12'h011, 0, 0, 1, 12'h020));
        s.push_back(st(0, LIT,  OP_NOP, 12'h300, 12'h000, 0, 1, 0)); e.push_back(mk(12'h004, 12'h300, 1, 0, 1, 12'h300));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h005, 12'h300, 1, 0, 1, 12'h301));
        s.push_back(st(0, SAVE, OP_RFI, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h300, 12'h300, 0, 0, 1, 12'h302));
        foreach (s[k]) begin
            exp_q.push_back(e[k]);
            step(s[k]);
            got  = cur();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL irq_priority[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_isr();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        s.push_back(st(0, LIT,  OP_NOP, 12'h040, 12'h000, 0, 0, 0)); e.push_back(mk(12'h040, 12'h300, 0, 0, 1, 12'h040));
        s.push_back(st(0, SAVE, OP_WFI, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h004, 12'h041, 1, 0, 1, 12'h041));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h005, 12'h041, 1, 0, 1, 12'h042));
        s.push_back(st(0, SAVE, OP_WFI, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h006, 12'h041, 1, 0, 1, 12'h043));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 1, 1, 1)); e.push_back(mk(12'h006, 12'h041, 1, 0, 1, 12'h043));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 1, 1, 1)); e.push_back(mk(12'h006, 12'h041, 1, 0, 1, 12'h043));
        s.push_back(st(0, SAVE, OP_RFI, 12'h000, 12'h000, 1, 1, 1)); e.push_back(mk(12'h006, 12'h041, 1, 0, 1, 12'h043));
        s.push_back(st(1, SAVE, OP_RFI, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h000, 12'h000, 0, 0, 1, 12'h000));
        foreach (s[k]) begin
            exp_q.push_back(e[k]);
            step(s[k]);
            got  = cur();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL isr[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got;
        obs_t  want;
        s.push_back(st(0, LIT,  OP_NOP, 12'h050, 12'h000, 0, 0, 0)); e.push_back(mk(12'h050, 12'h000, 0, 0, 1, 12'h050));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h004, 12'h051, 1, 0, 1, 12'h051));
        s.push_back(st(0, SAVE, OP_RFI, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h051, 12'h051, 0, 0, 1, 12'h052));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 1, 0)); e.push_back(mk(12'h004, 12'h052, 1, 0, 1, 12'h053));
        s.push_back(st(0, SAVE, OP_RFI, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h052, 12'h052, 0, 0, 1, 12'h054));
        s.push_back(st(0, SAVE, OP_RFI, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h053, 12'h052, 0, 0, 1, 12'h055));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 1, 1)); e.push_back(mk(12'h053, 12'h052, 0, 0, 1, 12'h055));
        s.push_back(st(0, ADD,  OP_NOP, 12'h000, 12'h000, 0, 0, 0)); e.push_back(mk(12'h054, 12'h052, 0, 0, 1, 12'h056));
        foreach (s[k]) begin
            exp_q.push_back(e[k]);
            step(s[k]);
            got  = cur();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap_branch();
        test_wfi();
        test_irq_priority();
        test_isr();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 12: program-counter width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: PC value after reset.
REQ-003 Parameter IRQ_VECTOR, default 12'h004: PC value on interrupt entry.
REQ-004 Single clock domain; reset is synchronous and active-high.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pc_mux  in  2  next-PC select from the instruction decoder: 0=ADD, 1=WREG, 2=LIT, 3=SAVE.
REQ-008 opcode  in  5  current opcode; opcode[4:1]=4'hE is wfi, 4'hF is rfi.
REQ-009 lit  in  PC_WIDTH  literal branch target.
REQ-010 w_reg  in  PC_WIDTH  W-register branch target.
REQ-011 skip  in  1  ALU skip flag for sms/smc; meaningful only when pc_mux=ADD.
REQ-012 irq  in  1  level-sensitive interrupt request.
REQ-013 stall  in  1  holds all state when high.
REQ-014 pc  out  PC_WIDTH  registered fetch address.
REQ-015 saved_pc  out  PC_WIDTH  registered return address.
REQ-016 interrupt_active  out  1  high while in state ISR.
REQ-017 waiting  out  1  high while in state WAIT.
REQ-018 fetch_valid  out  1  high when pc addresses an instruction to execute (state != WAIT).

Function
REQ-019 State machine has three states, RUN, WAIT and ISR, with one state register.
REQ-020 Next-PC candidate npc is selected as follows: ADD gives pc+1+skip; WREG gives w_reg; LIT gives lit; SAVE gives pc+1, except rfi in ISR, which gives saved_pc.
REQ-021 All PC arithmetic is modulo 2^PC_WIDTH, so 12'hFFF+1 gives 0 and 12'hFFF+2 gives 1.
REQ-022 In RUN with irq=0, each unstalled edge loads pc<=npc; wfi (SAVE with opcode[4:1]=E) additionally moves the state to WAIT.
REQ-023 In RUN with irq=1, the edge loads saved_pc<=npc and pc<=IRQ_VECTOR and moves to ISR; the interrupt takes priority over wfi in the same cycle.
REQ-024 In WAIT, pc holds, which is the wfi address +1.
REQ-025 In WAIT, irq=1 loads saved_pc<=pc and pc<=IRQ_VECTOR and moves to ISR.
REQ-026 In ISR, pc<=npc on each edge; irq is ignored (no nesting); wfi acts as pc+1.
REQ-027 rfi in ISR loads pc<=saved_pc and moves to RUN; a pending irq is taken no earlier than the following edge.
REQ-028 rfi in RUN or WAIT is a no-op: pc+1, no state change.
REQ-029 When stall=1 and reset=0, pc, saved_pc and the state all hold; irq is not latched.
REQ-030 interrupt_active, waiting and fetch_valid are decoded from the registered state and carry no combinational path from inputs.

Reset
REQ-031 At reset: pc=RESET_VECTOR, saved_pc=0, state=RUN, interrupt_active=0, waiting=0, fetch_valid=1.
REQ-032 Reset overrides stall, irq and any in-progress WAIT or ISR, and aborts an interrupt return without restoring saved_pc.

Configuration
REQ-033 Macro PC_SEQ_IRQ_EN compiles interrupt support in.
REQ-034 With PC_SEQ_IRQ_EN defined, behaviour is as REQ-019..REQ-032.
REQ-035 With PC_SEQ_IRQ_EN undefined:
- irq is ignored;
- wfi and rfi execute as pc+1;
- state is fixed at RUN;
- saved_pc, interrupt_active and waiting are tied to 0;
- fetch_valid is tied to 1;
- the ports remain present.

Verification
REQ-036 Reset, then 3 edges with pc_mux=ADD, skip=0 -> pc 0,1,2,3; then skip=1 -> pc=5.
REQ-037 pc=12'hFFE, ADD with skip=1 -> pc=0; then LIT with lit=12'h123 -> pc=12'h123; then WREG with w_reg=12'h0AA -> pc=12'h0AA.
REQ-038 pc=12'h010, wfi -> pc=12'h011, waiting=1, fetch_valid=0; irq=1 after 4 edges -> saved_pc=12'h011, pc=12'h004, interrupt_active=1.
REQ-039 pc=12'h020 with LIT lit=12'h300 and irq=1 on the same edge -> saved_pc=12'h300, pc=12'h004; later rfi -> pc=12'h300, state RUN.
REQ-040 In ISR, irq held high -> no re-entry and saved_pc unchanged; stall=1 for 3 edges -> pc unchanged; reset during ISR -> pc=0, interrupt_active=0.
REQ-041 Built without PC_SEQ_IRQ_EN, pc=12'h010: wfi -> pc=12'h011, waiting=0; irq=1 -> no vector taken.
